sobel_stream_unit: RTL

Parametrised streaming Sobel edge-magnitude engine for the hardcloud Sobel accelerator datapath. It consumes raster-order 8-bit grayscale pixels, PIXELS_PER_BEAT per beat. It emits one 32-bit RGB-replicated magnitude pixel per input pixel at a fixed pipeline latency. Unlike the first-generation unit, image width and height, beat width and frame resynchronisation are generic, and border pixels are forced to zero.

---
 rtl/sobel_stream_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sobel_stream_unit.sv
// Streaming Sobel edge-magnitude engine: raster 8-bit pixels in, RGB-replicated magnitude out, 2-cycle latency.
// Optional macro SOBEL_SATURATE_EN: clamp magnitude to 255 instead of wrapping modulo 256.
module sobel_stream_unit #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_WIDTH     = 512,
  parameter int IMAGE_HEIGHT    = 512
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         valid_in,
  input  logic                         sof_in,
  input  logic [8*PIXELS_PER_BEAT-1:0] data_in,
  output logic                         valid_out,
  output logic                         sof_out,
  output logic [32*PIXELS_PER_BEAT-1:0] data_out
);
  localparam int P      = PIXELS_PER_BEAT;
  localparam int BPL    = IMAGE_WIDTH / P;
  localparam int CB_W   = (BPL > 1) ? $clog2(BPL) : 1;
  localparam int R_W    = $clog2(IMAGE_HEIGHT);
  localparam int BEAT_W = 8 * P;
  localparam int G_W    = 12;

  function automatic logic signed [G_W-1:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                                 input logic [7:0] c);
    logic [G_W-1:0] s;
    s = {4'b0, a} + {3'b0, b, 1'b0} + {4'b0, c};
    return signed'(s);
  endfunction

  function automatic logic [G_W-1:0] abs_g(input logic signed [G_W-1:0] v);
    logic signed [G_W-1:0] n;
    n = -v;
    return v[G_W-1] ? unsigned'(n) : unsigned'(v);
  endfunction

  function automatic logic [7:0] reduce_mag(input logic [G_W-1:0] mag);
`ifdef SOBEL_SATURATE_EN
    return (mag > G_W'(255)) ? 8'hFF : 8'(mag);
`else
    return 8'(mag);
`endif
  endfunction

  logic [CB_W-1:0]   cb;
  logic [R_W-1:0]    r;
  logic [BEAT_W-1:0] line1 [BPL];
  logic [BEAT_W-1:0] line2 [BPL];
  logic [15:0]       prev_top, prev_mid, prev_bot;

  logic [CB_W-1:0]   cb_eff;
  logic [R_W-1:0]    r_eff;
  logic [BEAT_W-1:0] top_beat, mid_beat;

  // An sof beat behaves as the first beat of row 0 whatever the counters say.
  assign cb_eff   = sof_in ? '0 : cb;
  assign r_eff    = sof_in ? '0 : r;
  assign mid_beat = line1[cb_eff];
  assign top_beat = line2[cb_eff];

  logic [7:0]            ext_t [P+2];
  logic [7:0]            ext_m [P+2];
  logic [7:0]            ext_b [P+2];
  logic signed [G_W-1:0] gx_s0 [P];
  logic signed [G_W-1:0] gy_s0 [P];
  logic [P-1:0]          border_s0;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      ext_t[k] = prev_top[8*k +: 8];
      ext_m[k] = prev_mid[8*k +: 8];
      ext_b[k] = prev_bot[8*k +: 8];
    end
    for (int j = 0; j < P; j++) begin
      ext_t[j+2] = top_beat[8*j +: 8];
      ext_m[j+2] = mid_beat[8*j +: 8];
      ext_b[j+2] = data_in[8*j +: 8];
    end
    border_s0 = '0;
    for (int j = 0; j < P; j++) begin
      gx_s0[j] = wsum(ext_t[j+2], ext_m[j+2], ext_b[j+2]) - wsum(ext_t[j], ext_m[j], ext_b[j]);
      gy_s0[j] = wsum(ext_t[j], ext_t[j+1], ext_t[j+2]) - wsum(ext_b[j], ext_b[j+1], ext_b[j+2]);
      border_s0[j] = (r_eff < R_W'(2)) || ((cb_eff == '0) && (j < 2));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cb       <= '0;
      r        <= '0;
      prev_top <= '0;
      prev_mid <= '0;
      prev_bot <= '0;
      for (int i = 0; i < BPL; i++) begin
        line1[i] <= '0;
        line2[i] <= '0;
      end
    end else if (valid_in) begin
      line1[cb_eff] <= data_in;
      line2[cb_eff] <= mid_beat;
      prev_top      <= top_beat[BEAT_W-1 -: 16];
      prev_mid      <= mid_beat[BEAT_W-1 -: 16];
      prev_bot      <= data_in[BEAT_W-1 -: 16];
      if (cb_eff == CB_W'(BPL - 1)) begin
        cb <= '0;
        r  <= (r_eff == R_W'(IMAGE_HEIGHT - 1)) ? '0 : r_eff + 1'b1;
      end else begin
        cb <= cb_eff + 1'b1;
        r  <= r_eff;
      end
    end
  end

  // ---- stage 1: window gradients ----
  logic                  vld_p1, sof_p1;
  logic signed [G_W-1:0] gx_p1 [P];
  logic signed [G_W-1:0] gy_p1 [P];
  logic [P-1:0]          border_p1;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      vld_p1    <= 1'b0;
      sof_p1    <= 1'b0;
      border_p1 <= '0;
      for (int j = 0; j < P; j++) begin
        gx_p1[j] <= '0;
        gy_p1[j] <= '0;
      end
    end else begin
      vld_p1 <= valid_in;
      sof_p1 <= valid_in & sof_in;
      if (valid_in) begin
        border_p1 <= border_s0;
        for (int j = 0; j < P; j++) begin
          gx_p1[j] <= gx_s0[j];
          gy_p1[j] <= gy_s0[j];
        end
      end
    end
  end

  // ---- stage 2: magnitude, reduction, border mask ----
  logic                 vld_p2, sof_p2;
  logic [32*P-1:0]      data_p2;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      vld_p2  <= 1'b0;
      sof_p2  <= 1'b0;
      data_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      sof_p2 <= sof_p1;
      if (vld_p1) begin
        for (int j = 0; j < P; j++) begin
          data_p2[32*j +: 32] <= border_p1[j] ? 32'h0 :
            {8'h00, {3{reduce_mag(abs_g(gx_p1[j]) + abs_g(gy_p1[j]))}}};
        end
      end
    end
  end

  assign valid_out = vld_p2;
  assign sof_out   = sof_p2;
  assign data_out  = data_p2;

endmodule
